// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pulls bytes from a show-ahead TX FIFO and
// serializes them as start / data (LSB first) / stop frames on tx_out.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       emptyTx,
  input  logic [7:0] tx_data,
  output logic       trans_deq,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam int TMR_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W = $clog2(NUM_DATA_BITS);

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] STOP_LAST = TMR_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DATA_BITS - 1);

  logic [2:0]               state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic                     start_ok;

  // FIFO handshake: a frame may only begin when tx_enable=1 and emptyTx=0
  // (head byte valid). trans_deq is the single-cycle pop strobe, asserted
  // only in LOAD; the byte on tx_data during that cycle is the one sent.
  assign start_ok = tx_enable && !emptyTx;

  if (NUM_DATA_BITS < 8) begin : g_narrow
    logic unused_hi_bits;
    assign unused_hi_bits = ^tx_data[7:NUM_DATA_BITS];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = tx_data[NUM_DATA_BITS-1:0];
        timer_d = '0;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        // Last stop cycle doubles as the frame boundary: chain straight
        // into the next LOAD when more data is waiting.
        if (timer_q == STOP_LAST) begin
          timer_d = '0;
          state_d = start_ok ? S_LOAD : S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      S_START: tx_out = 1'b0;
      S_DATA:  tx_out = shift_q[0];
      default: tx_out = 1'b1;
    endcase
  end

  assign trans_deq = (state_q == S_LOAD);
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_done   = (state_q == S_STOP) && (timer_q == STOP_LAST);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model plus frame scoreboard on two instances
// (8N1 and 7-bit/2-stop), with directed timing checks.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] reset_s, tx_enable_s, empty_s;
  logic [1:0] deq_s, out_s, busy_s, done_s;
  logic [7:0] data0, data1;
  logic [2:0] state0, state1;

  logic [7:0] fifo0[$];
  logic [7:0] fifo1[$];
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int aborts   = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .tx_enable(tx_enable_s[0]), .emptyTx(empty_s[0]),
    .tx_data(data0), .trans_deq(deq_s[0]), .tx_out(out_s[0]), .tx_busy(busy_s[0]),
    .tx_done(done_s[0]), .dbg_state(state0)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(7), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .tx_enable(tx_enable_s[1]), .emptyTx(empty_s[1]),
    .tx_data(data1), .trans_deq(deq_s[1]), .tx_out(out_s[1]), .tx_busy(busy_s[1]),
    .tx_done(done_s[1]), .dbg_state(state1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    empty_s[0] = (fifo0.size() == 0);
    data0      = (fifo0.size() != 0) ? fifo0[0] : 8'h00;
    empty_s[1] = (fifo1.size() == 0);
    data1      = (fifo1.size() != 0) ? fifo1[0] : 8'h00;
  endtask

  task automatic push(input int id, input logic [7:0] b);
    if (id == 0) begin
      fifo0.push_back(b);
      exp0_q.push_back(b);
    end else begin
      fifo1.push_back(b);
      exp1_q.push_back(b);
    end
    fifo_refresh();
  endtask

  function automatic logic [8:0] pop_exp(input int id);
    if (id == 0) begin
      if (exp0_q.size() == 0) return 9'h000;
      return {1'b1, exp0_q.pop_front()};
    end
    if (exp1_q.size() == 0) return 9'h000;
    return {1'b1, exp1_q.pop_front()};
  endfunction

  // Per-cycle line level from the LOAD cycle through the last stop cycle.
  function automatic logic [63:0] frame_wave(input logic [7:0] b, input int ndb, input int sb);
    logic [63:0] w;
    int c;
    w = '0;
    c = 0;
    w[c] = 1'b1;
    c++;
    for (int i = 0; i < CPB; i++) begin w[c] = 1'b0; c++; end
    for (int k = 0; k < ndb; k++)
      for (int i = 0; i < CPB; i++) begin w[c] = b[k]; c++; end
    for (int i = 0; i < CPB * sb; i++) begin w[c] = 1'b1; c++; end
    return w;
  endfunction

  // FIFO model: pop after the edge that ends a LOAD cycle.
  initial begin
    logic [1:0] pop;
    forever begin
      @(posedge clk);
      pop = deq_s;
      #1;
      if (pop[0] && fifo0.size() > 0) void'(fifo0.pop_front());
      if (pop[1] && fifo1.size() > 0) void'(fifo1.pop_front());
      fifo_refresh();
    end
  end

  task automatic run_monitor(input int id);
    int ndb, sb, n, exp_len;
    logic [63:0] wave;
    logic in_frame, post_done;
    logic [8:0] eb;
    ndb       = (id == 0) ? 8 : 7;
    sb        = (id == 0) ? 1 : 2;
    exp_len   = 1 + CPB * (1 + ndb + sb);
    in_frame  = 1'b0;
    post_done = 1'b0;
    n         = 0;
    wave      = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset_s[id]) begin
        if (in_frame) begin
          aborts++;
          void'(pop_exp(id));
        end
        in_frame  = 1'b0;
        post_done = 1'b0;
        continue;
      end
      if (post_done) begin
        check("busy_after_done", busy_s[id], deq_s[id]);
        post_done = 1'b0;
      end
      if (deq_s[id]) begin
        check("deq_while_empty", empty_s[id], 1'b0);
        check("deq_once_per_frame", in_frame, 1'b0);
        in_frame = 1'b1;
        n        = 0;
        wave     = '0;
      end
      if (!in_frame) begin
        if (done_s[id]) check("done_outside_frame", done_s[id], 1'b0);
      end else begin
        if (n < 64) wave[n] = out_s[id];
        n++;
        if (done_s[id]) begin
          eb = pop_exp(id);
          check("frame_expected", eb[8], 1'b1);
          check("frame_len", n, exp_len);
          check("frame_wave", wave, frame_wave(eb[7:0], ndb, sb));
          in_frame  = 1'b0;
          post_done = 1'b1;
        end else if (n > 100) begin
          check("frame_timeout", n, exp_len);
          in_frame = 1'b0;
        end
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k, deqs, dones, lows, highs, busys, c_done1, c_done2, c_load2;
    logic [1:0] gap;

    reset_s     = 2'b11;
    tx_enable_s = 2'b01;
    fifo_refresh();
    push(0, 8'hA5);

    // Reset held two edges with data waiting and enable high.
    repeat (2) begin
      tick();
      check("reset_outputs0", {out_s[0], deq_s[0], busy_s[0], done_s[0], state0}, 7'b1000_000);
      check("reset_outputs1", {out_s[1], deq_s[1], busy_s[1], done_s[1], state1}, 7'b1000_000);
    end
    @(negedge clk);
    reset_s = 2'b00;
    k = 0;
    do begin
      tick();
      k++;
    end while (!deq_s[0] && k < 4);
    check("load_edge_after_reset", (k >= 1 && k <= 2), 1'b1);
    check("load_state", state0, 3'd1);

    // Single 0xA5 frame: LOAD is cycle 1, tx_done on cycle 41.
    k = 1;
    deqs = 1;
    while (!done_s[0] && k < 100) begin
      tick();
      k++;
      deqs += int'(deq_s[0]);
    end
    check("a5_done_cycle", k, 41);
    check("a5_deq_pulses", deqs, 1);
    tick();
    check("a5_busy_after_done", busy_s[0], 1'b0);

    // Back-to-back 0x00 then 0xFF.
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    deqs = 0; dones = 0; k = 0;
    c_done1 = -1; c_done2 = -1; c_load2 = -1; gap = 2'b00;
    while (dones < 2 && k < 200) begin
      tick();
      k++;
      if (deq_s[0]) begin
        deqs++;
        if (deqs == 2) c_load2 = k;
      end
      if (c_done1 >= 0 && k == c_done1 + 1) gap[0] = out_s[0];
      if (c_done1 >= 0 && k == c_done1 + 2) gap[1] = out_s[0];
      if (done_s[0]) begin
        dones++;
        if (dones == 1) c_done1 = k;
        if (dones == 2) c_done2 = k;
      end
    end
    check("b2b_deq_pulses", deqs, 2);
    check("b2b_done_pulses", dones, 2);
    check("b2b_load_follows_stop", c_load2 - c_done1, 1);
    check("b2b_gap_levels", gap, 2'b01);
    check("b2b_frame_period", c_done2 - c_done1, 41);

    // tx_enable low with data waiting: nothing moves.
    @(negedge clk);
    tx_enable_s[0] = 1'b0;
    push(0, 8'h5A);
    deqs = 0; lows = 0; busys = 0;
    repeat (50) begin
      tick();
      deqs  += int'(deq_s[0]);
      lows  += int'(!out_s[0]);
      busys += int'(busy_s[0]);
    end
    check("gate_no_deq", deqs, 0);
    check("gate_line_high", lows, 0);
    check("gate_not_busy", busys, 0);

    // Enable, then drop it during DATA with another byte queued.
    @(negedge clk);
    tx_enable_s[0] = 1'b1;
    deqs = 0; k = 0;
    while (state0 != 3'd3 && k < 20) begin
      tick();
      k++;
      deqs += int'(deq_s[0]);
    end
    check("gate_reached_data", state0, 3'd3);
    @(negedge clk);
    tx_enable_s[0] = 1'b0;
    push(0, 8'h77);
    k = 0;
    while (!done_s[0] && k < 60) begin
      tick();
      k++;
      deqs += int'(deq_s[0]);
    end
    check("gate_frame_done", done_s[0], 1'b1);
    busys = 0;
    repeat (30) begin
      tick();
      deqs  += int'(deq_s[0]);
      busys += int'(busy_s[0]);
    end
    check("gate_single_deq", deqs, 1);
    check("gate_idle_after", busys, 0);

    // Reset during data bit 3 of 0x77.
    @(negedge clk);
    tx_enable_s[0] = 1'b1;
    k = 0;
    while (state0 != 3'd3 && k < 20) begin
      tick();
      k++;
    end
    repeat (13) tick();
    check("bit3_before_reset", out_s[0], 1'b0);
    @(negedge clk);
    reset_s[0] = 1'b1;
    tick();
    check("reset_mid_frame", {out_s[0], state0, done_s[0], busy_s[0]}, 6'b1_000_00);
    @(negedge clk);
    reset_s[0] = 1'b0;
    deqs = 0; lows = 0;
    repeat (30) begin
      tick();
      deqs += int'(deq_s[0]);
      lows += int'(!out_s[0]);
    end
    check("no_retransmit_deq", deqs, 0);
    check("no_retransmit_line", lows, 0);
    check("abort_count", aborts, 1);
    @(negedge clk);
    push(0, 8'h81);
    k = 0;
    while (!done_s[0] && k < 60) begin
      tick();
      k++;
    end
    check("post_reset_frame_done", done_s[0], 1'b1);

    // 7 data bits, 2 stop bits, data 0x3C.
    @(negedge clk);
    tx_enable_s[1] = 1'b1;
    push(1, 8'h3C);
    k = 0;
    while (!deq_s[1] && k < 10) begin
      tick();
      k++;
    end
    check("b_load_seen", deq_s[1], 1'b1);
    k = 1;
    highs = 0;
    while (!done_s[1] && k < 100) begin
      tick();
      k++;
      highs = out_s[1] ? highs + 1 : 0;
    end
    check("b_frame_cycles", k, 41);
    check("b_stop_high", highs, 8);

    repeat (5) tick();
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);
    check("fifos_drained", fifo0.size() + fifo1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
